// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline_v0r1 stage and its skid buffer.
package pipeline_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} skid_state_t;

    localparam int STATS_BEAT_BITS = 32;
    localparam int STATS_PKT_BITS  = 16;

endpackage

// File: rtl/pipeline_skid.sv
// Registered-ready skid buffer with an opaque payload: ready is a flop, valid/data
// pass through combinationally while empty.
module pipeline_skid
    import pipeline_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    skid_state_t  r_state;
    logic         r_ready;
    logic [W-1:0] r_data;
    logic         w_in_fire;

    assign w_in_fire = i_valid & r_ready;

    // r_ready mirrors the state as its own flop so o_ready has no logic in front of it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_data  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire && !i_ready) begin
                        r_state <= FULL;
                        r_ready <= 1'b0;
                        r_data  <= i_data;
                    end
                end
                FULL: begin
                    if (i_ready) begin
                        r_state <= EMPTY;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state == FULL) | i_valid;
    assign o_data  = (r_state == FULL) ? r_data : i_data;

endmodule

// File: rtl/pipeline_v0r1.sv
// Registered-ready pipeline stage emitting the running prefix sum of each packet.
// Optional beat/packet/stall counters are enabled by defining PIPELINE_V0R1_STATS_EN.
module pipeline_v0r1
    import pipeline_pkg::*;
#(
    parameter int VALUE_BITS = 8,
    parameter int STATE_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [VALUE_BITS-1:0] i_value,
    input  logic                  i_last,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [VALUE_BITS-1:0] o_value,
    output logic                  o_last,
    output logic                  o_valid,
    input  logic                  i_ready
`ifdef PIPELINE_V0R1_STATS_EN
    ,
    output logic [STATS_BEAT_BITS-1:0] o_beats,
    output logic [STATS_PKT_BITS-1:0]  o_packets,
    output logic [STATS_BEAT_BITS-1:0] o_stalls
`endif
);

    if (STATE_BITS < VALUE_BITS) begin : g_width_check
        $error("pipeline_v0r1: STATE_BITS must be >= VALUE_BITS");
    end

    typedef struct packed {
        logic [VALUE_BITS-1:0] value;
        logic                  last;
    } beat_t;

    logic [STATE_BITS-1:0] r_acc;
    logic [STATE_BITS-1:0] w_sum;
    logic                  w_in_fire;
    beat_t                 w_in_beat;
    beat_t                 w_out_beat;

    assign w_sum           = r_acc + STATE_BITS'(i_value);
    assign w_in_beat.value = w_sum[VALUE_BITS-1:0];
    assign w_in_beat.last  = i_last;
    assign w_in_fire       = i_valid & o_ready;

    // A last beat clears the sum so the next beat opens a fresh packet.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (w_in_fire) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

    pipeline_skid #(
        .W($bits(beat_t))
    ) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .i_data  (w_in_beat),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (w_out_beat),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    assign o_value = w_out_beat.value;
    assign o_last  = w_out_beat.last;

`ifdef PIPELINE_V0R1_STATS_EN
    logic [STATS_BEAT_BITS-1:0] r_beats;
    logic [STATS_PKT_BITS-1:0]  r_packets;
    logic [STATS_BEAT_BITS-1:0] r_stalls;
    logic                       w_out_fire;

    assign w_out_fire = o_valid & i_ready;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_beats   <= '0;
            r_packets <= '0;
            r_stalls  <= '0;
        end else begin
            if (w_out_fire && (r_beats != '1))
                r_beats <= r_beats + 1'b1;
            if (w_out_fire && o_last && (r_packets != '1))
                r_packets <= r_packets + 1'b1;
            if (o_valid && !i_ready && (r_stalls != '1))
                r_stalls <= r_stalls + 1'b1;
        end
    end

    assign o_beats   = r_beats;
    assign o_packets = r_packets;
    assign o_stalls  = r_stalls;
`endif

endmodule

// File: tb/tb_pipeline_v0r1.sv
// Directed bench for pipeline_v0r1 with a prefix-sum reference model checked every cycle.
// Stats checks run only when PIPELINE_V0R1_STATS_EN is defined.
module tb_pipeline_v0r1;

    localparam int VB = 8;
    localparam int SB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VB-1:0] i_value = '0;
    logic          i_last = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic          o_ready;
    logic [VB-1:0] o_value;
    logic          o_last;
    logic          o_valid;
`ifdef PIPELINE_V0R1_STATS_EN
    logic [31:0]   o_beats;
    logic [15:0]   o_packets;
    logic [31:0]   o_stalls;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipeline_v0r1 #(.VALUE_BITS(VB), .STATE_BITS(SB)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .i_value (i_value),
        .i_last  (i_last),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_value (o_value),
        .o_last  (o_last),
        .o_valid (o_valid),
        .i_ready (i_ready)
`ifdef PIPELINE_V0R1_STATS_EN
        ,
        .o_beats   (o_beats),
        .o_packets (o_packets),
        .o_stalls  (o_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: running packet sum plus at most one held beat.
    int m_acc   = 0;
    bit m_held  = 1'b0;
    int m_hval  = 0;
    bit m_hlast = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int sum;
        if (!rst_n) begin
            m_acc  <= 0;
            m_held <= 1'b0;
            m_hval <= 0;
            m_hlast <= 1'b0;
        end else if (!m_held) begin
            if (i_valid) begin
                sum = (m_acc + int'(i_value)) % (1 << SB);
                m_acc <= i_last ? 0 : sum;
                if (!i_ready) begin
                    m_held  <= 1'b1;
                    m_hval  <= sum % (1 << VB);
                    m_hlast <= i_last;
                end
            end
        end else if (i_ready) begin
            m_held <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int e_valid, e_value, e_last;
        e_valid = m_held ? 1 : int'(i_valid);
        e_value = m_held ? m_hval : ((m_acc + int'(i_value)) % (1 << SB)) % (1 << VB);
        e_last  = m_held ? int'(m_hlast) : int'(i_last);
        check("model_ready", int'(o_ready), m_held ? 0 : 1);
        check("model_valid", int'(o_valid), e_valid);
        if (e_valid != 0) begin
            check("model_value", int'(o_value), e_value);
            check("model_last", int'(o_last), e_last);
        end
    end

    // Drive one cycle of inputs, then check hand-computed outputs mid-cycle.
    task automatic beat(input int v, input bit l, input bit vld, input bit rdy,
                        input int e_rdy, input int e_vld, input int e_val, input int e_lst,
                        input string name);
        i_value = VB'(v);
        i_last  = l;
        i_valid = vld;
        i_ready = rdy;
        @(negedge clk);
        check({name, "_ready"}, int'(o_ready), e_rdy);
        check({name, "_valid"}, int'(o_valid), e_vld);
        if (e_val >= 0) check({name, "_value"}, int'(o_value), e_val);
        if (e_lst >= 0) check({name, "_last"}, int'(o_last), e_lst);
        $display("beat %s: in=%0d last=%0d vld=%0d rdy=%0d -> out=%0d last=%0d vld=%0d ordy=%0d",
                 name, v, l, vld, rdy, o_value, o_last, o_valid, o_ready);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: pass-through of raw input, ready high.
        beat(0, 0, 0, 1, 1, 0, -1, -1, "rst_idle");
        beat(9, 1, 1, 1, 1, 1, 9, 1, "rst_pass");
        rst_n = 1'b1;

        beat(1, 0, 1, 1, 1, 1, 1, 0, "s1");
        beat(2, 0, 1, 1, 1, 1, 3, 0, "s2");
        beat(3, 0, 1, 1, 1, 1, 6, 0, "s3");
        beat(4, 1, 1, 1, 1, 1, 10, 1, "s4");

        // Stall: 5 accepted into skid, 7 offered while full is ignored.
        beat(5, 0, 1, 0, 1, 1, 5, 0, "st_load");
        beat(7, 1, 1, 0, 0, 1, 5, 0, "st_hold1");
        beat(7, 1, 1, 0, 0, 1, 5, 0, "st_hold2");
        beat(7, 1, 1, 0, 0, 1, 5, 0, "st_hold3");
        beat(7, 1, 1, 1, 0, 1, 5, 0, "st_drain");
        beat(7, 1, 1, 1, 1, 1, 12, 1, "st_after");

        // Wrap-around modulo 256.
        beat(200, 0, 1, 1, 1, 1, 200, 0, "w1");
        beat(100, 1, 1, 1, 1, 1, 44, 1, "w2");

        // Reset while full mid-packet.
        beat(4, 0, 1, 1, 1, 1, 4, 0, "r_a");
        beat(5, 0, 1, 0, 1, 1, 9, 0, "r_b");
        beat(0, 0, 0, 0, 0, 1, 9, 0, "r_full");
        rst_n = 1'b0;
        beat(6, 0, 1, 0, 1, 1, 6, 0, "r_inrst");
        rst_n = 1'b1;
        beat(3, 0, 1, 1, 1, 1, 3, 0, "r_after");
        beat(0, 0, 0, 1, 1, 0, -1, -1, "idle");

`ifdef PIPELINE_V0R1_STATS_EN
        rst_n = 1'b0;
        beat(0, 0, 0, 1, 1, 0, -1, -1, "sx_rst");
        rst_n = 1'b1;
        beat(1, 0, 1, 1, 1, 1, 1, 0, "p1a");
        beat(2, 0, 1, 1, 1, 1, 3, 0, "p1b");
        beat(3, 1, 1, 1, 1, 1, 6, 1, "p1c");
        beat(1, 0, 1, 0, 1, 1, 1, 0, "p2a_stall");
        beat(0, 0, 0, 0, 0, 1, 1, 0, "p2_s2");
        beat(0, 0, 0, 0, 0, 1, 1, 0, "p2_s3");
        beat(0, 0, 0, 0, 0, 1, 1, 0, "p2_s4");
        beat(0, 0, 0, 1, 0, 1, 1, 0, "p2_drain");
        beat(1, 0, 1, 1, 1, 1, 2, 0, "p2b");
        beat(1, 1, 1, 1, 1, 1, 3, 1, "p2c");
        beat(0, 0, 0, 1, 1, 0, -1, -1, "sx_idle");
        check("stats_beats", int'(o_beats), 6);
        check("stats_packets", int'(o_packets), 2);
        check("stats_stalls", int'(o_stalls), 4);
        $display("stats: beats=%0d packets=%0d stalls=%0d", o_beats, o_packets, o_stalls);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
